// File: rtl/i2c_codec_slave_if.sv
// I2C bus bundle between the codec-control master and the codec stand-in.
// SDA is open-drain: sdat_in is the resolved bus level, sdat_oe=1 pulls low.
interface i2c_codec_slave_if;
  logic I2C_SCLK;
  logic sdat_in;
  logic sdat_oe;

  modport master (
    output I2C_SCLK,
    output sdat_in,
    input  sdat_oe
  );

  modport slave (
    input  I2C_SCLK,
    input  sdat_in,
    output sdat_oe
  );
endinterface

// File: rtl/i2c_codec_slave.sv
// WM8731-style write-only I2C control-port responder.
// Oversamples SCL/SDA, decodes 3-byte writes, ACKs them and commits them
// into a small 9-bit register file with volume/activity taps.
//
// Bus handshake: there is no valid/ready; a write is reported by wr_valid,
// a single-clock pulse with wr_reg/wr_data stable from that cycle until the
// next commit. The slave never stretches SCL.
module i2c_codec_slave #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_REGS  = 10,
  parameter logic [6:0] RESET_REG = 7'h0F
) (
  input  logic                clk,
  input  logic                reset,
  i2c_codec_slave_if.slave    bus,
  output logic                wr_valid,
  output logic [6:0]          wr_reg,
  output logic [8:0]          wr_data,
  output logic [8:0]          vol_l,
  output logic [8:0]          vol_r,
  output logic                active,
  input  logic [3:0]          dbg_idx,
  output logic [8:0]          dbg_data,
  output logic [7:0]          xfer_cnt,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_ACK_A  = 3'd2,
    S_REG    = 3'd3,
    S_ACK_R  = 3'd4,
    S_DATA   = 3'd5,
    S_ACK_D  = 3'd6,
    S_IGNORE = 3'd7
  } state_t;

  // Power-on contents of the codec register file.
  function automatic logic [8:0] reg_default(input int idx);
    case (idx)
      0, 1:    reg_default = 9'h097;
      2, 3:    reg_default = 9'h079;
      4:       reg_default = 9'h00A;
      5:       reg_default = 9'h008;
      6:       reg_default = 9'h09F;
      7:       reg_default = 9'h00A;
      default: reg_default = 9'h000;
    endcase
  endfunction

  // Synchronizer and edge-detect history.
  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;

  // Protocol state.
  state_t     r_state;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic       r_byte_done;
  logic [6:0] r_reg_idx;
  logic       r_d8;
  logic       r_sdat_oe;
  logic       r_wr_valid;
  logic [6:0] r_wr_reg;
  logic [8:0] r_wr_data;
  logic [7:0] r_xfer_cnt;

  logic [8:0] r_regs [NUM_REGS];

  logic       w_scl_rise, w_scl_fall;
  logic       w_start, w_stop;
  logic       w_commit, w_restore;
  logic [8:0] w_dbg_data;

  // Synchronizer runs freely through reset so that releasing reset in the
  // middle of bus activity never produces a phantom edge; the FSM ignores
  // the bus until the next START anyway.
  always_ff @(posedge clk) begin
    r_scl_s1 <= bus.I2C_SCLK;
    r_scl_s2 <= r_scl_s1;
    r_scl_d  <= r_scl_s2;
    r_sda_s1 <= bus.sdat_in;
    r_sda_s2 <= r_sda_s1;
    r_sda_d  <= r_sda_s2;
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // SDA edges qualify as conditions only when SCL was high on both samples.
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  // Third byte finished and its ACK is being driven: commit the write.
  assign w_commit   = ~w_start & ~w_stop & w_scl_fall & r_byte_done &
                      (r_state == S_DATA);
  assign w_restore  = w_commit & (r_reg_idx == RESET_REG);

  // Protocol FSM: byte reception, ACK drive and commit reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'd0;
      r_byte_done <= 1'b0;
      r_reg_idx   <= 7'd0;
      r_d8        <= 1'b0;
      r_sdat_oe   <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_reg    <= 7'd0;
      r_wr_data   <= 9'd0;
      r_xfer_cnt  <= 8'd0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_start) begin
        r_state     <= S_ADDR;
        r_bitcnt    <= 3'd0;
        r_byte_done <= 1'b0;
        r_sdat_oe   <= 1'b0;
      end else if (w_stop) begin
        r_state     <= S_IDLE;
        r_bitcnt    <= 3'd0;
        r_byte_done <= 1'b0;
        r_sdat_oe   <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_REG, S_DATA: begin
            if (w_scl_rise && !r_byte_done) begin
              r_shift  <= {r_shift[6:0], r_sda_s2};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) r_byte_done <= 1'b1;
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              if (r_state == S_ADDR) begin
                if (r_shift[7:1] == DEV_ADDR && !r_shift[0]) begin
                  r_sdat_oe <= 1'b1;
                  r_state   <= S_ACK_A;
                end else begin
                  r_state   <= S_IGNORE;
                end
              end else if (r_state == S_REG) begin
                r_reg_idx <= r_shift[7:1];
                r_d8      <= r_shift[0];
                r_sdat_oe <= 1'b1;
                r_state   <= S_ACK_R;
              end else begin
                r_sdat_oe  <= 1'b1;
                r_state    <= S_ACK_D;
                r_wr_valid <= 1'b1;
                r_wr_reg   <= r_reg_idx;
                r_wr_data  <= {r_d8, r_shift};
                r_xfer_cnt <= r_xfer_cnt + 8'd1;
              end
            end
          end
          S_ACK_A, S_ACK_R, S_ACK_D: begin
            if (w_scl_fall) begin
              r_sdat_oe <= 1'b0;
              r_bitcnt  <= 3'd0;
              case (r_state)
                S_ACK_A: r_state <= S_REG;
                S_ACK_R: r_state <= S_DATA;
                default: r_state <= S_IGNORE;  // a 4th byte is never ACKed
              endcase
            end
          end
          default: ;  // IDLE / IGNORE wait for START
        endcase
      end
    end
  end

  // Register file: defaults on reset or a write to RESET_REG, else commit.
  always_ff @(posedge clk) begin
    if (reset || w_restore) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= reg_default(i);
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_reg_idx == 7'(i)) r_regs[i] <= {r_d8, r_shift};
      end
    end
  end

  // Debug read port: out-of-range indices read as zero.
  always_comb begin
    w_dbg_data = 9'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i < 16 && dbg_idx == 4'(i)) w_dbg_data = r_regs[i];
    end
  end

  assign bus.sdat_oe = r_sdat_oe;
  assign wr_valid    = r_wr_valid;
  assign wr_reg      = r_wr_reg;
  assign wr_data     = r_wr_data;
  assign xfer_cnt    = r_xfer_cnt;
  assign vol_l       = r_regs[2];
  assign vol_r       = r_regs[3];
  assign active      = r_regs[9][0];
  assign dbg_data    = w_dbg_data;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_i2c_codec_slave.sv
// Directed bench for the codec control-port responder: an open-drain I2C
// master model, a commit scoreboard and a final report.
module tb_i2c_codec_slave;

  localparam int Q = 10;  // clk cycles per SCL quarter phase

  logic       clk;
  logic       reset;
  logic       r_scl;
  logic       r_sda;      // master side, 1 = released
  logic       wr_valid;
  logic [6:0] wr_reg;
  logic [8:0] wr_data;
  logic [8:0] vol_l, vol_r, dbg_data;
  logic       active;
  logic [3:0] dbg_idx;
  logic [7:0] xfer_cnt;
  logic [2:0] dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int push_cnt  = 0;
  int oe_spur   = 0;
  logic [15:0] exp_q[$];

  i2c_codec_slave_if bus ();
  assign bus.I2C_SCLK = r_scl;
  assign bus.sdat_in  = r_sda & ~bus.sdat_oe;

  i2c_codec_slave dut (
    .clk(clk), .reset(reset), .bus(bus),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data),
    .vol_l(vol_l), .vol_r(vol_r), .active(active),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data),
    .xfer_cnt(xfer_cnt), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver tasks
  task automatic i2c_start();
    r_sda = 1'b1; wait_clk(Q);
    r_scl = 1'b1; wait_clk(Q);
    r_sda = 1'b0; wait_clk(Q);
    r_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    r_sda = 1'b0; wait_clk(Q);
    r_scl = 1'b1; wait_clk(Q);
    r_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      r_sda = b[i]; wait_clk(Q);
      r_scl = 1'b1; wait_clk(Q);
      if (bus.sdat_oe) oe_spur++;
      r_scl = 1'b0; wait_clk(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    r_sda = 1'b1; wait_clk(Q);
    r_scl = 1'b1; wait_clk(Q / 2);
    ack = ~bus.sdat_in;
    wait_clk(Q / 2);
    r_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write3(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic exp_ack);
    logic a;
    i2c_start();
    send_byte(b0, a); check_eq({tag, "_ack0"}, a, exp_ack);
    send_byte(b1, a); check_eq({tag, "_ack1"}, a, exp_ack);
    send_byte(b2, a); check_eq({tag, "_ack2"}, a, exp_ack);
    i2c_stop();
  endtask

  task automatic expect_commit(input logic [6:0] rg, input logic [8:0] d);
    exp_q.push_back({rg, d});
    push_cnt++;
  endtask

  // Scoreboard: every wr_valid pulse must match the oldest expected commit
  always @(negedge clk) begin
    if (!reset && wr_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) check_eq("unexpected_commit", {16'd0, wr_reg, wr_data}, 32'hFFFF);
      else check_eq("commit", {16'd0, wr_reg, wr_data}, {16'd0, exp_q.pop_front()});
    end
  end

  initial begin
    logic a;
    reset = 1'b1; r_scl = 1'b1; r_sda = 1'b1; dbg_idx = 4'd0;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);

    // Reset state
    check_eq("rst_oe", bus.sdat_oe, 0);
    check_eq("rst_wr_reg", wr_reg, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_xfer", xfer_cnt, 0);
    check_eq("rst_vol_l", vol_l, 9'h079);
    check_eq("rst_vol_r", vol_r, 9'h079);
    check_eq("rst_active", active, 0);
    check_eq("rst_state", dbg_state, 0);
    dbg_idx = 4'd0;  #1 check_eq("rst_r0", dbg_data, 9'h097);
    dbg_idx = 4'd6;  #1 check_eq("rst_r6", dbg_data, 9'h09F);
    dbg_idx = 4'd12; #1 check_eq("dbg_oob", dbg_data, 0);

    // Left volume write
    expect_commit(7'd2, 9'h055);
    write3("w_voll", 8'h34, 8'h04, 8'h55, 1'b1);
    check_eq("voll", vol_l, 9'h055);
    check_eq("volr_keep", vol_r, 9'h079);
    check_eq("xfer1", xfer_cnt, 1);
    check_eq("wr_reg1", wr_reg, 2);
    check_eq("pulse1", pulse_cnt, 1);

    // Right volume with data bit 8 from the register byte
    expect_commit(7'd3, 9'h155);
    write3("w_volr", 8'h34, 8'h07, 8'h55, 1'b1);
    check_eq("volr", vol_r, 9'h155);
    dbg_idx = 4'd3; #1 check_eq("dbg_r3", dbg_data, 9'h155);
    check_eq("xfer2", xfer_cnt, 2);

    // Wrong address and a read: never ACKed, nothing commits
    write3("w_badaddr", 8'h36, 8'h04, 8'h11, 1'b0);
    i2c_start(); send_byte(8'h35, a); check_eq("read_nack", a, 0); i2c_stop();
    check_eq("xfer_nack", xfer_cnt, 2);
    check_eq("voll_nack", vol_l, 9'h055);

    // Activate, then restore defaults via the reset register
    expect_commit(7'd9, 9'h001);
    write3("w_act", 8'h34, 8'h12, 8'h01, 1'b1);
    check_eq("active1", active, 1);
    expect_commit(7'h0F, 9'h000);
    write3("w_rst", 8'h34, 8'h1E, 8'h00, 1'b1);
    check_eq("wr_reg_rst", wr_reg, 7'h0F);
    check_eq("voll_def", vol_l, 9'h079);
    check_eq("volr_def", vol_r, 9'h079);
    check_eq("active0", active, 0);
    check_eq("xfer4", xfer_cnt, 4);

    // Repeated START after the register byte discards the partial write
    i2c_start();
    send_byte(8'h34, a); check_eq("rs_ack0", a, 1);
    send_byte(8'h04, a); check_eq("rs_ack1", a, 1);
    expect_commit(7'd9, 9'h001);
    write3("w_rs", 8'h34, 8'h12, 8'h01, 1'b1);
    check_eq("rs_active", active, 1);
    check_eq("rs_voll", vol_l, 9'h079);
    check_eq("xfer5", xfer_cnt, 5);

    // A 4th byte is not ACKed
    expect_commit(7'd4, 9'h0AA);
    i2c_start();
    send_byte(8'h34, a); send_byte(8'h08, a); send_byte(8'hAA, a);
    send_byte(8'h11, a); check_eq("byte4_nack", a, 0);
    i2c_stop();
    dbg_idx = 4'd4; #1 check_eq("dbg_r4", dbg_data, 9'h0AA);

    // Out-of-range index: acknowledged and reported, file unchanged
    expect_commit(7'h10, 9'h033);
    write3("w_oor", 8'h34, 8'h20, 8'h33, 1'b1);
    check_eq("oor_r4", dbg_data, 9'h0AA);
    check_eq("xfer7", xfer_cnt, 7);
    check_eq("oe_spur", oe_spur, 0);

    // Reset pulse while the register byte is being ACKed
    i2c_start();
    send_byte(8'h34, a);
    send_bits(8'h04);
    r_sda = 1'b1; wait_clk(6);
    check_eq("ackr_oe", bus.sdat_oe, 1);
    check_eq("ackr_state", dbg_state, 3'd4);
    reset = 1'b1; wait_clk(1); reset = 1'b0;
    check_eq("mr_oe", bus.sdat_oe, 0);
    check_eq("mr_xfer", xfer_cnt, 0);
    check_eq("mr_state", dbg_state, 0);
    check_eq("mr_active", active, 0);
    check_eq("mr_r4", dbg_data, 9'h00A);
    i2c_stop();
    expect_commit(7'd2, 9'h066);
    write3("w_after", 8'h34, 8'h04, 8'h66, 1'b1);
    check_eq("after_voll", vol_l, 9'h066);
    check_eq("after_xfer", xfer_cnt, 1);

    // Final report
    wait_clk(5);
    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("pulse_total", pulse_cnt, push_cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
